// File: rtl/window_mul_sequencer.sv
// window_mul_sequencer: pairs each input sample with its window coefficient and sequences one multiply per sample
module window_mul_sequencer #(
  parameter int FRAME_LEN   = 256,
  parameter int IDX_W       = 8,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [IDX_W-1:0] coef_addr,
  input  logic [15:0]      coef_data,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic             mul_enable,
  input  logic [15:0]      mul_product,
  input  logic             mul_done,
  output logic [15:0]      m_data,
  output logic [IDX_W-1:0] m_index,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready
);
  localparam int CNT_W = $clog2(MUL_LATENCY) + 1;
  typedef enum logic [2:0] {IDLE, FETCH, MUL, WAIT, OUT} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] cnt;
  logic cnt_top, cap;
  assign cnt_top = cnt == CNT_W'(MUL_LATENCY - 1);
  assign cap = state == WAIT && cnt_top && mul_done;
  // state register; async reset returns to IDLE immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and state-decoded outputs; ROM address is the live index so data is ready in FETCH
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = s_valid ? FETCH : IDLE;
      FETCH:   state_nx = MUL;
      MUL:     state_nx = WAIT;
      WAIT:    state_nx = cap ? OUT : WAIT;
      OUT:     state_nx = m_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
    s_ready    = state == IDLE;
    mul_enable = state == MUL;
    m_valid    = state == OUT;
    m_last     = state == OUT && index == IDX_W'(FRAME_LEN - 1);
    coef_addr  = index;
    m_index    = index;
  end
  // datapath: operands held until WAIT exits, counter gates out stale mul_done levels
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      index  <= '0;
      cnt    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      m_data <= '0;
    end else begin
      index <= flush ? '0 : (state == OUT && m_ready) ? index + 1'b1 : index;
      cnt   <= state == MUL ? '0 : (state == WAIT && !cnt_top) ? cnt + 1'b1 : cnt;
      if (state == IDLE && s_valid && !flush) mul_a <= s_data;
      if (state == FETCH) mul_b <= coef_data;
      if (cap && !flush) m_data <= mul_product;
    end
endmodule
